// File: rtl/fsm_periph_pkg.sv
// Shared encodings for the 4-phase send/ack link between the processor and peripheral FSMs.
package fsm_periph_pkg;

   localparam logic [1:0] SEND_IDLE = 2'b00;
   localparam logic [1:0] SEND_REQ  = 2'b01;
   localparam logic [1:0] ACK_IDLE  = 2'b00;
   localparam logic [1:0] ACK_OK    = 2'b01;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      REQ      = 2'b01,
      WAIT_REL = 2'b10
   } tx_state_t;

endpackage

// File: rtl/periph_tx_fifo.sv
// Small synchronous FIFO buffering core words until the link FSM transmits them.
module periph_tx_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] head,
   output logic              empty,
   output logic              full
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   // full is derived from the registered count, so a push while full is dropped
   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fsm_processador_tx.sv
// Processor-side initiator of the 4-phase send/ack link: FIFO-fed words, timeout abort,
// transfer counter and sticky timeout flag.
module fsm_processador_tx
   import fsm_periph_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic [DATA_W-1:0] dado,
   output logic [1:0]        send,
   input  logic [1:0]        ack,
   output logic              busy,
   output logic              timeout_err,
   input  logic              err_clr,
   output logic [7:0]        sent_cnt
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   tx_state_t         state;
   tx_state_t         state_nxt;
   logic [TW-1:0]     tcnt;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_empty;
   logic              pop;
   logic              load;
   logic              cnt_inc;
   logic              to_hit;

   periph_tx_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (wr_en),
      .pop    (pop),
      .wr_data(wr_data),
      .head   (fifo_head),
      .empty  (fifo_empty),
      .full   (full)
   );

   assign busy = (state != IDLE) || !fifo_empty;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load      = 1'b0;
      cnt_inc   = 1'b0;
      to_hit    = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nxt = REQ;
               load      = 1'b1;
            end
         end
         REQ: begin
            // the word leaves the FIFO whether acknowledged or abandoned on timeout
            if (ack == ACK_OK) begin
               state_nxt = WAIT_REL;
               pop       = 1'b1;
               cnt_inc   = 1'b1;
            end else if (tcnt == TMAX) begin
               state_nxt = WAIT_REL;
               pop       = 1'b1;
               to_hit    = 1'b1;
            end
         end
         WAIT_REL: begin
            if (ack != ACK_OK) begin
               state_nxt = IDLE;
            end else if (tcnt == TMAX) begin
               state_nxt = IDLE;
               to_hit    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         send        <= SEND_IDLE;
         dado        <= '0;
         tcnt        <= '0;
         sent_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         // send mirrors the state it will be in, so it is a clean registered output
         send  <= (state_nxt == REQ) ? SEND_REQ : SEND_IDLE;
         if (load) dado <= fifo_head;
         if (state_nxt != state) tcnt <= '0;
         else if (state != IDLE && tcnt != TMAX) tcnt <= tcnt + 1'b1;
         if (cnt_inc) sent_cnt <= sent_cnt + 8'd1;
         if (to_hit) timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fsm_processador_tx.sv
// Scoreboard bench for fsm_processador_tx against a small peripheral ack model.
module tb_fsm_processador_tx;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int TO     = 255;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic [DATA_W-1:0] dado;
   logic [1:0]        send;
   logic [1:0]        ack;
   logic              busy;
   logic              timeout_err;
   logic              err_clr;
   logic [7:0]        sent_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] sb [$];
   int delivered = 0;
   int low_run   = 0;
   bit prev_hi   = 0;
   bit seen_word = 0;
   int mode      = 0;   // 0 registered ack, 1 ack held 00, 2 ack sticks at 01

   always #5 clk = ~clk;

   fsm_processador_tx #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT   (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .full       (full),
      .dado       (dado),
      .send       (send),
      .ack        (ack),
      .busy       (busy),
      .timeout_err(timeout_err),
      .err_clr    (err_clr),
      .sent_cnt   (sent_cnt)
   );

   // peripheral: ack is a registered decode of send
   always @(posedge clk or posedge rst) begin
      if (rst) ack <= 2'b00;
      else begin
         case (mode)
            0:       ack <= (send == 2'b01) ? 2'b01 : 2'b00;
            1:       ack <= 2'b00;
            default: if (send == 2'b01) ack <= 2'b01;
         endcase
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // monitor: every rising send presents one word, compared against the scoreboard
   always @(negedge clk) begin
      logic [DATA_W-1:0] exp_w;
      if (!rst && send == 2'b01 && !prev_hi) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL dado_unexpected: got %h, scoreboard empty", dado);
         end else begin
            exp_w = sb.pop_front();
            if (dado !== exp_w) begin
               n_fail++;
               $display("FAIL dado_order: got %h, expected %h", dado, exp_w);
            end
         end
         if (seen_word) begin
            n_checks++;
            if (low_run < 2) begin
               n_fail++;
               $display("FAIL idle_gap: got %0d low cycles, expected >=2", low_run);
            end
         end
         seen_word = 1;
         delivered++;
      end
      low_run = (send == 2'b01) ? 0 : low_run + 1;
      prev_hi = (send == 2'b01);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d, input bit accepted);
      wr_en   = 1'b1;
      wr_data = d;
      if (accepted) sb.push_back(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_rise();
      int n = 0;
      while (send != 2'b01 && n < 20) begin
         tick();
         n++;
      end
      check("send_rise", int'(send == 2'b01), 1);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((busy || sb.size() != 0) && n < bound) begin
         tick();
         n++;
      end
      check("idle_reached", int'(n < bound), 1);
   endtask

   task automatic feed(input int n, input logic [DATA_W-1:0] base);
      int pushed = 0;
      int d0     = delivered;
      int guard  = 0;
      while (pushed < n && guard < 4000) begin
         if (pushed - (delivered - d0) <= 2) begin
            wr_en   = 1'b1;
            wr_data = base + DATA_W'(pushed);
            sb.push_back(wr_data);
            pushed++;
         end else begin
            wr_en = 1'b0;
         end
         tick();
         guard++;
      end
      wr_en = 1'b0;
      check("feed_done", pushed, n);
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      err_clr = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_send", int'(send), 0);
      check("rst_dado", int'(dado), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err", int'(timeout_err), 0);
      rst = 1'b0;
      tick();

      // reset mid-REQ with a full FIFO
      mode = 1;
      push_word(16'h1234, 1);
      push_word(16'h2222, 1);
      push_word(16'h3333, 1);
      push_word(16'h4444, 1);
      wait_rise();
      check("pre_rst_full", int'(full), 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_send", int'(send), 0);
      check("mid_rst_dado", int'(dado), 0);
      check("mid_rst_full", int'(full), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_cnt", int'(sent_cnt), 0);
      sb.delete();
      tick();
      rst  = 1'b0;
      mode = 0;
      tick();

      // single word, cycle-exact
      push_word(16'hA5A5, 1);
      check("sw_c0_send", int'(send), 0);
      check("sw_c0_busy", int'(busy), 1);
      tick();
      check("sw_c1_send", int'(send), 1);
      check("sw_c1_dado", int'(dado), 16'hA5A5);
      tick();
      check("sw_c2_send", int'(send), 1);
      check("sw_c2_ack", int'(ack), 1);
      tick();
      check("sw_c3_send", int'(send), 0);
      tick();
      check("sw_c4_busy", int'(busy), 1);
      tick();
      check("sw_c5_busy", int'(busy), 0);
      check("sw_cnt", int'(sent_cnt), 1);
      check("sw_dado_hold", int'(dado), 16'hA5A5);

      // burst of 5 into a depth-4 FIFO, peripheral stalled meanwhile
      mode = 1;
      push_word(16'h1111, 1);
      push_word(16'h2222, 1);
      push_word(16'h3333, 1);
      push_word(16'h4444, 1);
      check("burst_full4", int'(full), 1);
      push_word(16'h5555, 0);
      check("burst_full5", int'(full), 1);
      mode = 0;
      wait_idle(200);
      check("burst_cnt", int'(sent_cnt), 5);

      // REQ timeout
      mode = 1;
      push_word(16'hDEAD, 1);
      wait_rise();
      n = 0;
      while (send == 2'b01 && n < 400) begin
         n++;
         tick();
      end
      check("req_to_len", n, TO + 1);
      check("req_to_err", int'(timeout_err), 1);
      check("req_to_cnt", int'(sent_cnt), 5);
      wait_idle(20);
      mode = 0;
      push_word(16'hBEEF, 1);
      wait_idle(50);
      check("after_to_cnt", int'(sent_cnt), 6);
      check("err_sticky", int'(timeout_err), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_cleared", int'(timeout_err), 0);

      // err_clr in the very cycle a timeout fires
      mode = 1;
      push_word(16'hC0DE, 1);
      wait_rise();
      repeat (TO) tick();
      check("last_req_send", int'(send), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("set_wins", int'(timeout_err), 1);
      check("set_wins_send", int'(send), 0);
      wait_idle(20);
      check("set_wins_cnt", int'(sent_cnt), 6);

      // ack stuck at 01 -> WAIT_REL timeout
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      mode = 2;
      push_word(16'h5A5A, 1);
      wait_rise();
      n = 0;
      while (send == 2'b01 && n < 10) begin
         n++;
         tick();
      end
      n = 0;
      while (busy && n < 400) begin
         n++;
         tick();
      end
      check("wrel_to_len", n, TO + 1);
      check("wrel_to_err", int'(timeout_err), 1);
      check("wrel_to_cnt", int'(sent_cnt), 7);
      tick();
      check("ack_in_idle", int'(busy), 0);
      mode = 0;
      repeat (2) tick();

      // counter wrap and FIFO pointer wrap with overlapping push/pop
      feed(248, 16'h8000);
      wait_idle(100);
      check("wrap_255", int'(sent_cnt), 255);
      push_word(16'hF00D, 1);
      wait_idle(50);
      check("wrap_0", int'(sent_cnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
